// File: rtl/vga_timing_gen_if.sv
// Display-side bundle of vga_timing_gen: pixel enable in, sync/enable/coordinate outputs.
// XW/YW must match the generator's clog2(VISIBLE >> SCALE_SHIFT) widths.
interface vga_timing_gen_if #(
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 8
);
    logic          ce;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic          line_start;
    logic          frame_start;
    logic          vblank;

    modport master (
        input  ce,
        output hsync,
        output vsync,
        output de,
        output px_x,
        output px_y,
        output line_start,
        output frame_start,
        output vblank
    );

    modport slave (
        output ce,
        input  hsync,
        input  vsync,
        input  de,
        input  px_x,
        input  px_y,
        input  line_start,
        input  frame_start,
        input  vblank
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised progressive raster timing generator with pixel-clock enable, sync polarity,
// power-of-two coordinate downscaling, line/frame strobes and vertical-blank flag.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          H_POL       = 1'b0,
    parameter bit          V_POL       = 1'b0,
    parameter int unsigned SCALE_SHIFT = 1
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned XW      = ((H_VISIBLE >> SCALE_SHIFT) > 1) ?
                                      $clog2(H_VISIBLE >> SCALE_SHIFT) : 1;
    localparam int unsigned YW      = ((V_VISIBLE >> SCALE_SHIFT) > 1) ?
                                      $clog2(V_VISIBLE >> SCALE_SHIFT) : 1;

    // Sync end never reaches TOTAL because the back porch is at least one unit.
    localparam logic [HCW-1:0] H_LAST       = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_VIS_END    = HCW'(H_VISIBLE);
    localparam logic [HCW-1:0] H_SYNC_START = HCW'(H_VISIBLE + H_FRONT);
    localparam logic [HCW-1:0] H_SYNC_END   = HCW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VCW-1:0] V_LAST       = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_VIS_END    = VCW'(V_VISIBLE);
    localparam logic [VCW-1:0] V_SYNC_START = VCW'(V_VISIBLE + V_FRONT);
    localparam logic [VCW-1:0] V_SYNC_END   = VCW'(V_VISIBLE + V_FRONT + V_SYNC);

    if (SCALE_SHIFT > 3 || H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_param_check
        $fatal(1, "vga_timing_gen: SCALE_SHIFT must be 0..3 and timing parameters non-zero");
    end

    logic [HCW-1:0] hcount_q;
    logic [VCW-1:0] vcount_q;

    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;
    logic [XW-1:0] px_x_q;
    logic [YW-1:0] px_y_q;
    logic          line_start_q;
    logic          frame_start_q;
    logic          vblank_q;

    logic          h_last;
    logic          v_last;
    logic          h_vis;
    logic          v_vis;
    logic          h_sync_act;
    logic          v_sync_act;
    logic          de_d;
    logic [XW-1:0] px_x_d;
    logic [YW-1:0] px_y_d;

    // Decode of the current (pre-increment) raster position.
    always_comb begin
        h_last     = (hcount_q == H_LAST);
        v_last     = (vcount_q == V_LAST);
        h_vis      = (hcount_q < H_VIS_END);
        v_vis      = (vcount_q < V_VIS_END);
        h_sync_act = (hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END);
        v_sync_act = (vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END);
        de_d       = h_vis && v_vis;
        px_x_d     = '0;
        px_y_d     = '0;
        if (de_d) begin
            px_x_d = XW'(hcount_q >> SCALE_SHIFT);
            px_y_d = YW'(vcount_q >> SCALE_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            // Strobes last one clk regardless of ce; everything else holds while ce=0.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (vga.ce) begin
                if (h_last) begin
                    hcount_q <= '0;
                    vcount_q <= v_last ? '0 : vcount_q + VCW'(1);
                end else begin
                    hcount_q <= hcount_q + HCW'(1);
                end
                hsync_q       <= h_sync_act ? H_POL : ~H_POL;
                vsync_q       <= v_sync_act ? V_POL : ~V_POL;
                de_q          <= de_d;
                px_x_q        <= px_x_d;
                px_y_q        <= px_y_d;
                line_start_q  <= (hcount_q == '0) && v_vis;
                frame_start_q <= (hcount_q == '0) && (vcount_q == '0);
                vblank_q      <= !v_vis;
            end
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.px_x        = px_x_q;
    assign vga.px_y        = px_y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.vblank      = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations share clk/rst/ce; a position-based model feeds a
// per-instance scoreboard, and each scenario task measures periods, widths and corner values.
module tb_vga_timing_gen;

    typedef struct packed {
        int hv, hf, hs, hb, vv, vf, vs, vb, sh;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic        hs, vs, de;
        logic [15:0] x, y;
        logic        ls, fs, vb;
    } obs_t;

    localparam cfg_t CFG_A = '{hv: 8, hf: 2, hs: 2, hb: 2, vv: 4, vf: 1, vs: 1, vb: 1, sh: 0,
                               hp: 1'b1, vp: 1'b1};
    localparam cfg_t CFG_B = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
                               sh: 1, hp: 1'b0, vp: 1'b0};
    localparam cfg_t CFG_C = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
                               sh: 2, hp: 1'b0, vp: 1'b0};
    localparam cfg_t CFG_D = '{hv: 64, hf: 4, hs: 8, hb: 4, vv: 48, vf: 2, vs: 2, vb: 4,
                               sh: 2, hp: 1'b0, vp: 1'b0};

    logic clk;
    logic rst;
    logic ce;

    int     errors;
    int     checks;
    int     cyc;
    longint n;
    obs_t   last [4];
    obs_t   sbq  [4][$];
    obs_t   obs  [4];
    obs_t   exp_o;

    vga_timing_gen_if #(.XW(3), .YW(2)) ifa ();
    vga_timing_gen_if #(.XW(9), .YW(8)) ifb ();
    vga_timing_gen_if #(.XW(8), .YW(7)) ifc ();
    vga_timing_gen_if #(.XW(4), .YW(4)) ifd ();

    assign ifa.ce = ce;
    assign ifb.ce = ce;
    assign ifc.ce = ce;
    assign ifd.ce = ce;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1'b1), .V_POL(1'b1), .SCALE_SHIFT(0)
    ) u_a (.clk(clk), .rst(rst), .vga(ifa));

    vga_timing_gen u_b (.clk(clk), .rst(rst), .vga(ifb));

    vga_timing_gen #(.SCALE_SHIFT(2)) u_c (.clk(clk), .rst(rst), .vga(ifc));

    vga_timing_gen #(
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
        .H_POL(1'b0), .V_POL(1'b0), .SCALE_SHIFT(2)
    ) u_d (.clk(clk), .rst(rst), .vga(ifd));

    assign obs[0] = {ifa.hsync, ifa.vsync, ifa.de, 16'(ifa.px_x), 16'(ifa.px_y),
                     ifa.line_start, ifa.frame_start, ifa.vblank};
    assign obs[1] = {ifb.hsync, ifb.vsync, ifb.de, 16'(ifb.px_x), 16'(ifb.px_y),
                     ifb.line_start, ifb.frame_start, ifb.vblank};
    assign obs[2] = {ifc.hsync, ifc.vsync, ifc.de, 16'(ifc.px_x), 16'(ifc.px_y),
                     ifc.line_start, ifc.frame_start, ifc.vblank};
    assign obs[3] = {ifd.hsync, ifd.vsync, ifd.de, 16'(ifd.px_x), 16'(ifd.px_y),
                     ifd.line_start, ifd.frame_start, ifd.vblank};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cfg_t cfg_of(input int i);
        case (i)
            0:       return CFG_A;
            1:       return CFG_B;
            2:       return CFG_C;
            default: return CFG_D;
        endcase
    endfunction

    function automatic obs_t reset_obs(input cfg_t c);
        obs_t o;
        o    = '0;
        o.hs = ~c.hp;
        o.vs = ~c.vp;
        return o;
    endfunction

    // Raster position is recovered from n, the number of ce edges since reset.
    function automatic obs_t model_out(input cfg_t c, input longint pos);
        obs_t o;
        int ht, vt, h, v, xw, yw;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        h  = int'(pos % longint'(ht));
        v  = int'((pos / longint'(ht)) % longint'(vt));
        xw = 1;
        while ((1 << xw) < (c.hv >> c.sh)) xw++;
        yw = 1;
        while ((1 << yw) < (c.vv >> c.sh)) yw++;
        o.hs = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.hp : ~c.hp;
        o.vs = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.vp : ~c.vp;
        o.de = (h < c.hv) && (v < c.vv);
        o.x  = o.de ? 16'((h >> c.sh) % (1 << xw)) : 16'd0;
        o.y  = o.de ? 16'((v >> c.sh) % (1 << yw)) : 16'd0;
        o.ls = (h == 0) && (v < c.vv);
        o.fs = (h == 0) && (v == 0);
        o.vb = (v >= c.vv);
        return o;
    endfunction

    // Drive one clk of stimulus and queue what each instance must show after that edge.
    task automatic step(input logic c, input logic r);
        obs_t e;
        ce  = c;
        rst = r;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                e = reset_obs(cfg_of(i));
            end else if (c) begin
                e = model_out(cfg_of(i), n);
            end else begin
                e    = last[i];
                e.ls = 1'b0;
                e.fs = 1'b0;
            end
            sbq[i].push_back(e);
            last[i] = e;
        end
        if (r) n = 0;
        else if (c) n++;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sbq[i].size() > 0) begin
                exp_o = sbq[i].pop_front();
                checks++;
                if (obs[i] !== exp_o) begin
                    errors++;
                    $display("FAIL scoreboard dut%0d cycle %0d: got %h want %h",
                             i, cyc, obs[i], exp_o);
                end
            end
        end
    end

    task automatic test_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if ({ifa.hsync, ifa.vsync} !== 2'b00) begin
            errors++; $display("FAIL reset_pol_a: got %b want 00", {ifa.hsync, ifa.vsync});
        end
        checks++;
        if ({ifb.hsync, ifb.vsync, ifb.de, ifb.line_start, ifb.frame_start, ifb.vblank}
            !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags_b: got %b want 110000",
                     {ifb.hsync, ifb.vsync, ifb.de, ifb.line_start, ifb.frame_start, ifb.vblank});
        end
        checks++;
        if (ifb.px_x !== 9'd0 || ifb.px_y !== 8'd0) begin
            errors++; $display("FAIL reset_px_b: got %0d,%0d want 0,0", ifb.px_x, ifb.px_y);
        end
    endtask

    task automatic test_continuous();
        int t_ls1 = -1, t_ls2 = -1, t_hs_fall = -1, hs_low = 0, de_b = 0;
        int t_fd1 = -1, t_fd2 = -1, vs_low_d = 0, de_d = 0, max_xd = 0, max_yd = 0, max_xc = 0;
        int t_fa1 = -1, t_fa2 = -1, hs_hi_a = 0, vs_hi_a = 0, t_la = -1, hs_off_a = -1;
        step(1'b0, 1'b1);
        for (int k = 0; k < 9000; k++) begin
            step(1'b1, 1'b0);
            if (ifb.line_start) begin
                if (t_ls1 < 0) t_ls1 = k;
                else if (t_ls2 < 0) t_ls2 = k;
            end
            if (t_ls1 >= 0 && t_ls2 < 0) begin
                if (!ifb.hsync) begin
                    hs_low++;
                    if (t_hs_fall < 0) t_hs_fall = k;
                end
                if (ifb.de) de_b++;
            end
            if (ifd.frame_start) begin
                if (t_fd1 < 0) t_fd1 = k;
                else if (t_fd2 < 0) t_fd2 = k;
            end
            if (t_fd1 >= 0 && t_fd2 < 0) begin
                if (!ifd.vsync) vs_low_d++;
                if (ifd.de) de_d++;
            end
            if (int'(ifd.px_x) > max_xd) max_xd = int'(ifd.px_x);
            if (int'(ifd.px_y) > max_yd) max_yd = int'(ifd.px_y);
            if (int'(ifc.px_x) > max_xc) max_xc = int'(ifc.px_x);
            if (ifa.frame_start) begin
                if (t_fa1 < 0) t_fa1 = k;
                else if (t_fa2 < 0) t_fa2 = k;
            end
            if (t_fa1 >= 0 && t_fa2 < 0) begin
                if (ifa.hsync) hs_hi_a++;
                if (ifa.vsync) vs_hi_a++;
            end
            if (ifa.line_start && t_la < 0) t_la = k;
            if (t_la >= 0 && hs_off_a < 0 && ifa.hsync) hs_off_a = k - t_la;
        end
        checks++;
        if (t_ls2 - t_ls1 !== 800) begin
            errors++; $display("FAIL line_period_b: got %0d want 800", t_ls2 - t_ls1);
        end
        checks++;
        if (t_hs_fall - t_ls1 !== 656) begin
            errors++; $display("FAIL hsync_offset_b: got %0d want 656", t_hs_fall - t_ls1);
        end
        checks++;
        if (hs_low !== 96) begin errors++; $display("FAIL hsync_width_b: got %0d want 96", hs_low); end
        checks++;
        if (de_b !== 640) begin errors++; $display("FAIL de_per_line_b: got %0d want 640", de_b); end
        checks++;
        if (t_fd2 - t_fd1 !== 4480) begin
            errors++; $display("FAIL frame_period_d: got %0d want 4480", t_fd2 - t_fd1);
        end
        checks++;
        if (vs_low_d !== 160) begin
            errors++; $display("FAIL vsync_width_d: got %0d want 160", vs_low_d);
        end
        checks++;
        if (de_d !== 3072) begin errors++; $display("FAIL de_per_frame_d: got %0d want 3072", de_d); end
        checks++;
        if (max_xd !== 15 || max_yd !== 11) begin
            errors++; $display("FAIL px_range_d: got %0d,%0d want 15,11", max_xd, max_yd);
        end
        checks++;
        if (max_xc !== 159) begin errors++; $display("FAIL px_x_max_c: got %0d want 159", max_xc); end
        checks++;
        if (t_fa2 - t_fa1 !== 98) begin
            errors++; $display("FAIL frame_period_a: got %0d want 98", t_fa2 - t_fa1);
        end
        checks++;
        if (hs_hi_a !== 14 || vs_hi_a !== 14) begin
            errors++; $display("FAIL sync_high_a: got %0d,%0d want 14,14", hs_hi_a, vs_hi_a);
        end
        checks++;
        if (hs_off_a !== 10) begin
            errors++; $display("FAIL hsync_start_a: got %0d want 10", hs_off_a);
        end
    endtask

    task automatic test_ce_toggle();
        int t1 = -1, t2 = -1, hs_low = 0, run = 0, max_run = 0, holds_bad = 0;
        int t_fa1 = -1, t_fa2 = -1;
        logic prev_hs = 1'b1, prev_de = 1'b0;
        step(1'b0, 1'b1);
        for (int k = 0; k < 3400; k++) begin
            step(k % 2 == 0, 1'b0);
            if (ifb.line_start) begin
                run++;
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            if (t1 >= 0 && t2 < 0 && !ifb.hsync) hs_low++;
            if (k % 2 == 1 && (ifb.hsync !== prev_hs || ifb.de !== prev_de)) holds_bad++;
            prev_hs = ifb.hsync;
            prev_de = ifb.de;
            if (ifa.frame_start) begin
                if (t_fa1 < 0) t_fa1 = k;
                else if (t_fa2 < 0) t_fa2 = k;
            end
        end
        checks++;
        if (t2 - t1 !== 1600) begin errors++; $display("FAIL line_period_ce: got %0d want 1600", t2 - t1); end
        checks++;
        if (max_run !== 1) begin errors++; $display("FAIL ls_width_ce: got %0d want 1", max_run); end
        checks++;
        if (hs_low !== 192) begin errors++; $display("FAIL hsync_width_ce: got %0d want 192", hs_low); end
        checks++;
        if (holds_bad !== 0) begin errors++; $display("FAIL hold_ce: got %0d want 0", holds_bad); end
        checks++;
        if (t_fa2 - t_fa1 !== 196) begin
            errors++; $display("FAIL frame_period_a_ce: got %0d want 196", t_fa2 - t_fa1);
        end
    endtask

    task automatic test_bursty();
        int nce = 0, fs_a = 0, ls_d = 0;
        logic c;
        step(1'b0, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            c = 1'($urandom_range(0, 1));
            step(c, 1'b0);
            if (c) nce++;
            if (ifa.frame_start) fs_a++;
            if (ifd.line_start) ls_d++;
        end
        checks++;
        if (fs_a !== (nce + 97) / 98) begin
            errors++; $display("FAIL bursty_fs_a: got %0d want %0d", fs_a, (nce + 97) / 98);
        end
        checks++;
        if (ls_d !== (nce + 79) / 80) begin
            errors++; $display("FAIL bursty_ls_d: got %0d want %0d", ls_d, (nce + 79) / 80);
        end
    endtask

    task automatic test_midframe_reset();
        step(1'b0, 1'b1);
        repeat (1601) step(1'b1, 1'b0);
        checks++;
        if ({ifd.line_start, ifd.de, ifd.px_y} !== {1'b1, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL pre_reset_d: got ls=%b de=%b y=%0d want ls=1 de=1 y=5",
                     ifd.line_start, ifd.de, ifd.px_y);
        end
        step(1'b1, 1'b1);
        checks++;
        if ({ifd.hsync, ifd.vsync, ifd.de, ifd.line_start, ifd.frame_start, ifd.vblank,
             ifd.px_x, ifd.px_y} !== {6'b110000, 8'd0}) begin
            errors++;
            $display("FAIL midreset_d: got ls=%b de=%b x=%0d y=%0d want all reset",
                     ifd.line_start, ifd.de, ifd.px_x, ifd.px_y);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (ifd.de !== 1'b0 || ifd.frame_start !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset_d: got de=%b fs=%b want 0,0", ifd.de, ifd.frame_start);
        end
        step(1'b1, 1'b0);
        checks++;
        if ({ifb.frame_start, ifb.line_start, ifb.de, ifb.px_x, ifb.px_y} !== {3'b111, 17'd0}) begin
            errors++;
            $display("FAIL first_ce_b: got fs=%b ls=%b de=%b x=%0d y=%0d want 1,1,1,0,0",
                     ifb.frame_start, ifb.line_start, ifb.de, ifb.px_x, ifb.px_y);
        end
        checks++;
        if ({ifa.frame_start, ifa.line_start, ifa.de, ifa.px_x, ifa.px_y} !== {3'b111, 5'd0}) begin
            errors++;
            $display("FAIL first_ce_a: got fs=%b ls=%b de=%b x=%0d y=%0d want 1,1,1,0,0",
                     ifa.frame_start, ifa.line_start, ifa.de, ifa.px_x, ifa.px_y);
        end
        repeat (30) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (ifd.de !== 1'b0 || ifd.px_x !== 4'd0 || ifb.hsync !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_line: got de=%b x=%0d hs_b=%b want 0,0,1",
                     ifd.de, ifd.px_x, ifb.hsync);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1);
        repeat (98) step(1'b1, 1'b0);
        checks++;
        if ({ifa.vblank, ifa.de} !== 2'b10) begin
            errors++; $display("FAIL last_pixel_a: got vb=%b de=%b want 1,0", ifa.vblank, ifa.de);
        end
        step(1'b1, 1'b0);
        checks++;
        if ({ifa.vblank, ifa.de, ifa.frame_start, ifa.line_start} !== 4'b0111) begin
            errors++;
            $display("FAIL wrap_a: got vb=%b de=%b fs=%b ls=%b want 0,1,1,1",
                     ifa.vblank, ifa.de, ifa.frame_start, ifa.line_start);
        end
        repeat (4381) step(1'b1, 1'b0);
        checks++;
        if ({ifd.vblank, ifd.de} !== 2'b10) begin
            errors++; $display("FAIL last_pixel_d: got vb=%b de=%b want 1,0", ifd.vblank, ifd.de);
        end
        step(1'b1, 1'b0);
        checks++;
        if ({ifd.vblank, ifd.de, ifd.frame_start, ifd.line_start} !== 4'b0111) begin
            errors++;
            $display("FAIL wrap_d: got vb=%b de=%b fs=%b ls=%b want 0,1,1,1",
                     ifd.vblank, ifd.de, ifd.frame_start, ifd.line_start);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        n      = 0;
        ce     = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #2;
        test_reset();
        test_continuous();
        test_ce_toggle();
        test_bursty();
        test_midframe_reset();
        test_wrap();
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of test want completion within 2 ms");
        $fatal(1, "timeout");
    end

endmodule
